key_entry_collector: RTL

KEY_ENTRY_COLLECTOR -- requirements
Module: key_entry_collector

---
 rtl/key_entry_collector.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/key_entry_collector.sv
// key_entry_collector: gathers four hex digits plus a mode bit from a keypad
// strobe and emits them as one 17-bit word, followed by a lockout period.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     [4:0] 0x00-0x0F digit, 0x10 ENTER, 0x11 CLEAR, 0x12 MODE,
//                0x13-0x1F ignored
//   data_out     [16:0] {mode, d3, d2, d1, d0}, d3 is the first digit keyed
//   data_load    one-cycle pulse, data_out valid while high
//   digit_count  [2:0] digits held, 0-4
//   entry_busy   high while collecting, emitting or in lockout
//   entry_error  one-cycle pulse on a rejected entry
//
// Parameters: HOLDOFF_CYCLES (1-255) lockout length after an emit;
// TIMEOUT_CYCLES (2-65535) inactivity limit while collecting.
// Optional feature macro: ENTRY_TIMEOUT_EN enables the inactivity timeout.
// Without it, collection persists until ENTER, CLEAR or reset.
module key_entry_collector #(
    parameter int HOLDOFF_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic [16:0] data_out,
    output logic        data_load,
    output logic [2:0]  digit_count,
    output logic        entry_busy,
    output logic        entry_error
);

    // Elaboration-time range checks on the parameters.
    if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES out of range");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT,
        S_HOLD
    } state_t;

    state_t      state, state_d;
    logic [15:0] digits, digits_d;
    logic [2:0]  count, count_d;
    logic        mode, mode_d;
    logic [16:0] dout_d;
    logic [7:0]  hold_cnt, hold_d;
    logic        err_d;

`ifdef ENTRY_TIMEOUT_EN
    logic [15:0] timer, timer_d;
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

    logic k_digit, k_enter, k_clear, k_mode;

    always_comb begin
        k_digit = key_valid && !key_code[4];
        k_enter = key_valid && (key_code == 5'h10);
        k_clear = key_valid && (key_code == 5'h11);
        k_mode  = key_valid && (key_code == 5'h12);
    end

    always_comb begin
        state_d  = state;
        digits_d = digits;
        count_d  = count;
        mode_d   = mode;
        dout_d   = data_out;
        hold_d   = hold_cnt;
        err_d    = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        timer_d  = timer;
`endif
        case (state)
            S_IDLE: begin
                unique case (1'b1)
                    k_digit: begin
                        digits_d = {12'h000, key_code[3:0]};
                        count_d  = 3'd1;
                        state_d  = S_COLLECT;
`ifdef ENTRY_TIMEOUT_EN
                        timer_d  = '0;
`endif
                    end
                    k_mode:  mode_d = ~mode;
                    default: ;
                endcase
            end
            S_COLLECT: begin
`ifdef ENTRY_TIMEOUT_EN
                // Any recognised key restarts the inactivity timer.
                timer_d = (k_digit || k_enter || k_clear || k_mode)
                        ? '0 : timer + 16'd1;
`endif
                unique case (1'b1)
                    k_digit: begin
                        // A fifth digit is silently dropped.
                        if (count < 3'd4) begin
                            digits_d = {digits[11:0], key_code[3:0]};
                            count_d  = count + 3'd1;
                        end
                    end
                    k_mode:  mode_d = ~mode;
                    k_enter: begin
                        if (count == 3'd4) begin
                            dout_d  = {mode, digits};
                            state_d = S_EMIT;
                        end else begin
                            err_d    = 1'b1;
                            digits_d = '0;
                            count_d  = '0;
                            mode_d   = 1'b0;
                            state_d  = S_IDLE;
                        end
                    end
                    k_clear: begin
                        digits_d = '0;
                        count_d  = '0;
                        mode_d   = 1'b0;
                        state_d  = S_IDLE;
                    end
                    default: begin
`ifdef ENTRY_TIMEOUT_EN
                        if (timer == TIMER_LAST) begin
                            err_d    = 1'b1;
                            digits_d = '0;
                            count_d  = '0;
                            mode_d   = 1'b0;
                            state_d  = S_IDLE;
                        end
`endif
                    end
                endcase
            end
            S_EMIT: begin
                digits_d = '0;
                count_d  = '0;
                mode_d   = 1'b0;
                hold_d   = 8'(HOLDOFF_CYCLES);
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                // Leaving on the edge where the count reaches zero gives
                // exactly HOLDOFF_CYCLES cycles in this state.
                hold_d = hold_cnt - 8'd1;
                if (hold_cnt <= 8'd1) begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            digits      <= '0;
            count       <= '0;
            mode        <= 1'b0;
            hold_cnt    <= '0;
            data_out    <= '0;
            data_load   <= 1'b0;
            entry_busy  <= 1'b0;
            entry_error <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            state       <= state_d;
            digits      <= digits_d;
            count       <= count_d;
            mode        <= mode_d;
            hold_cnt    <= hold_d;
            data_out    <= dout_d;
            data_load   <= (state_d == S_EMIT);
            entry_busy  <= (state_d != S_IDLE);
            entry_error <= err_d;
`ifdef ENTRY_TIMEOUT_EN
            timer       <= timer_d;
`endif
        end
    end

    assign digit_count = count;

endmodule
